// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------------------------------------------------------------------
// Receive-side byte FIFO sitting between a UART receiver and a consumer.
// Bytes are pushed by a single-cycle strobe from the receiver and popped
// by the consumer. The head byte is presented first-word fall-through.
// A sticky flag records any byte that had to be dropped because the FIFO
// was full.
//
// Parameters
//   DEPTH             number of byte entries (power of two, 4..256)
//   AW                pointer width, log2(DEPTH)
//
// Ports
//   clk               system clock, all state on the rising edge
//   rst_n             asynchronous active-low reset
//   in_rx_byte        byte from the UART receiver
//   in_rx_valid       single-cycle strobe qualifying in_rx_byte
//   in_read           consumer pop request, one byte per asserted cycle
//   in_flush          synchronous empty request
//   in_clear_overflow clears the sticky overflow flag
//   out_data          head byte, valid while out_available is high
//   out_available     FIFO non-empty
//   out_full          FIFO holds DEPTH bytes
//   out_count         number of stored bytes, 0..DEPTH
//   out_overflow      sticky flag, set when a byte is dropped
// ------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_rx_byte,
    input  logic          in_rx_valid,
    input  logic          in_read,
    input  logic          in_flush,
    input  logic          in_clear_overflow,
    output logic [7:0]    out_data,
    output logic          out_available,
    output logic          out_full,
    output logic [AW:0]   out_count,
    output logic          out_overflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]  mem_q [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          pop_ok;
    logic          push_ok;
    logic          drop;
    logic          mem_we;

    // A push into a full FIFO is still taken when a pop frees a slot in
    // the same cycle; only a push that finds no room is dropped. A flush
    // overrides any push or pop that cycle, so storage is not written then.
    always_comb begin
        pop_ok  = in_read && (count_q != '0);
        push_ok = in_rx_valid && ((count_q != FULL_COUNT) || pop_ok);
        drop    = in_rx_valid && !push_ok;
        mem_we  = push_ok && !in_flush;

        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (in_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow_d = 1'b1;
            end else if (in_clear_overflow) begin
                overflow_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wptr_q] <= in_rx_byte;
        end
    end

    assign out_data      = mem_q[rptr_q];
    assign out_available = (count_q != '0);
    assign out_full      = (count_q == FULL_COUNT);
    assign out_count     = count_q;
    assign out_overflow  = overflow_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of byte entries; legal values are powers of two from 4 to 256.
REQ-002 SHALL have parameter AW, default 4, meaning pointer width; it SHALL equal log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: 50 MHz system clock; all state is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_rx_byte, input, 8 bits: byte from the UART receiver.
REQ-006 SHALL have port in_rx_valid, input, 1 bit: single-cycle strobe marking in_rx_byte valid.
REQ-007 SHALL have port in_read, input, 1 bit: consumer pop request, one byte per asserted cycle.
REQ-008 SHALL have port in_flush, input, 1 bit: synchronous empty request.
REQ-009 SHALL have port in_clear_overflow, input, 1 bit: clears the sticky overflow flag.
REQ-010 SHALL have port out_data, output, 8 bits: head byte, first-word fall-through.
REQ-011 SHALL have port out_available, output, 1 bit: FIFO non-empty; out_data is valid while high.
REQ-012 SHALL have port out_full, output, 1 bit: count equals DEPTH.
REQ-013 SHALL have port out_count, output, AW+1 bits: number of stored bytes.
REQ-014 SHALL have port out_overflow, output, 1 bit: sticky flag, set when a byte is dropped.

Function
REQ-015 SHALL store bytes in a DEPTH x 8 array indexed by AW-bit write and read pointers that wrap modulo DEPTH.
REQ-016 SHALL track occupancy in an (AW+1)-bit count, range 0..DEPTH, updated on the same edge as the pointers.
REQ-017 SHALL accept a push when in_rx_valid=1 and (count<DEPTH or a pop is accepted in the same cycle): write the byte at wptr, then increment wptr.
REQ-018 SHALL accept a pop when in_read=1 and count>0: increment rptr.
REQ-019 SHALL ignore in_read when count==0, with no pointer or count change and no error.
REQ-020 SHALL, on simultaneous accepted push and pop, leave count unchanged and advance both pointers.
REQ-021 SHALL, when full with push and pop in the same cycle, accept both, leave count at DEPTH, and not set overflow.
REQ-022 SHALL, when empty with push and pop in the same cycle, ignore the pop and accept the push, giving count 1.
REQ-023 SHALL, on a push while full without a pop, drop the byte, leave storage unchanged, and set out_overflow=1 on the next edge.
REQ-024 SHALL keep out_overflow set until in_clear_overflow=1; if a clear and a drop occur in the same cycle, the drop wins and the flag stays 1.
REQ-025 SHALL make out_data equal mem[rptr] combinationally; the first byte SHALL appear one cycle after its push edge.
REQ-026 SHALL derive out_available and out_full combinationally from count.
REQ-027 SHALL, on in_flush=1, set wptr=rptr=0 and count=0 on the next edge, overriding any push or pop that cycle; overflow SHALL be unchanged.
REQ-028 SHALL leave out_data undefined when out_available=0; consumers SHALL NOT sample it.

Reset
REQ-029 SHALL, while rst_n=0, force wptr=0, rptr=0, count=0 and out_overflow=0 asynchronously, regardless of clk.
REQ-030 SHALL produce reset outputs out_available=0, out_full=0, out_count=0 and out_overflow=0.
REQ-031 SHALL NOT reset the storage array; contents after reset are don't-care.
REQ-032 SHALL, if reset is asserted mid-operation, discard all stored bytes; the first push after release SHALL be read back first.
REQ-033 SHALL synchronise deassertion of rst_n externally; the block SHALL accept pushes from the first clk edge after release.

Verification
REQ-034 SHALL cover this scenario: push 0x41, 0x42, 0x43 on alternate cycles, then pop three times -> out_data reads 0x41, 0x42, 0x43; count goes 3,2,1,0; out_available falls after the third pop.
REQ-035 SHALL cover this scenario: push 16 bytes 0x00..0x0F, then push 0xAA -> out_full=1, count=16, out_overflow=1; pops return 0x00..0x0F and 0xAA is never seen.
REQ-036 SHALL cover this scenario: with full FIFO, push 0x55 and pop in the same cycle -> count stays 16, overflow stays 0, 0x55 is the 16th subsequent pop.
REQ-037 SHALL cover this scenario: with empty FIFO, push 0x7E and pop in the same cycle -> count=1, out_data=0x7E.
REQ-038 SHALL cover this scenario: load 5 bytes, assert in_flush together with a push -> count=0, out_available=0; a later push of 0x31 is read back first.
REQ-039 SHALL cover this scenario: load 7 bytes, drive rst_n low mid-cycle -> count=0 immediately, before the next clk edge; overflow=0; storage and pointers wrap correctly over 40 push/pop pairs.
